// File: rtl/sort_uart_pkg.sv
// Shared types and helpers for the sort -> UART framing path.
// Holds the framer state encoding and the CRC-8 (poly 0x07) byte step.
package sort_uart_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        DONE
    } framer_state_t;

    // MSB-first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_chk.sv
// Frame check accumulator: two's-complement sum by default,
// CRC-8 when UART_TX_FRAMER_CRC8_EN is defined.
module frame_chk
    import sort_uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_chk
);

    logic [7:0] r_acc;
    logic [7:0] w_acc_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_nxt;
        end
    end

`ifdef UART_TX_FRAMER_CRC8_EN
    assign w_acc_nxt = crc8_step(r_acc, i_data);
    assign o_chk     = r_acc;
`else
    // Negated sum makes the receiver's running sum land on zero.
    assign w_acc_nxt = r_acc + i_data;
    assign o_chk     = ~r_acc + 8'd1;
`endif

endmodule

// File: rtl/uart_tx_framer.sv
// Frames one captured sorted array as SOF, SEQ, LEN, payload, CHK for uart_tx.
// CHK is a negated sum, or CRC-8 when UART_TX_FRAMER_CRC8_EN is defined.
module uart_tx_framer
    import sort_uart_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter logic [7:0]  SOF     = SOF_DEFAULT,
    parameter int unsigned BUSY_TO = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [DEPTH-1:0][WIDTH-1:0] array_in,
    output logic                        ready_out,
    input  logic                        tx_busy,
    output logic [7:0]                  byte_out,
    output logic                        start_out,
    output logic                        frame_done,
    output logic                        drop
);

    localparam int unsigned BPE   = WIDTH / 8;
    localparam int unsigned NB    = WIDTH * DEPTH / 8;
    localparam int unsigned LAST  = NB + 3;
    localparam int unsigned IDX_W = $clog2(NB + 4);
    localparam int unsigned TO_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

    framer_state_t               r_state;
    framer_state_t               w_state_nxt;

    logic [DEPTH-1:0][WIDTH-1:0] r_shadow;
    logic [IDX_W-1:0]            r_idx;
    logic [TO_W-1:0]             r_to_cnt;
    logic [7:0]                  r_seq;
    logic [7:0]                  r_byte;
    logic                        r_start;
    logic                        r_done;
    logic                        r_drop;
    logic                        r_ready;

    logic                        w_capture;
    logic                        w_last;
    logic                        w_to_expired;
    logic                        w_start_set;
    logic                        w_done_set;
    logic                        w_idx_inc;
    logic                        w_chk_en;
    logic [7:0]                  w_chk;
    logic [7:0]                  w_pay_sel;
    logic [7:0]                  w_sel_byte;
    logic [7:0]                  w_pay [NB];

    assign w_capture    = valid_in & r_ready;
    assign w_last       = (r_idx == IDX_W'(LAST));
    assign w_to_expired = (r_to_cnt == TO_W'(BUSY_TO - 1));

    // Flatten the shadow into a byte stream: element 0 first, MSB byte first.
    for (genvar e = 0; e < DEPTH; e++) begin : g_el
        for (genvar b = 0; b < BPE; b++) begin : g_by
            assign w_pay[e*BPE + b] = r_shadow[e][WIDTH-1-8*b -: 8];
        end
    end

    always_comb begin
        w_pay_sel = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (r_idx == IDX_W'(k + 3)) begin
                w_pay_sel = w_pay[k];
            end
        end
    end

    always_comb begin
        if (r_idx == '0) begin
            w_sel_byte = SOF;
        end else if (r_idx == IDX_W'(1)) begin
            w_sel_byte = r_seq;
        end else if (r_idx == IDX_W'(2)) begin
            w_sel_byte = 8'(NB);
        end else if (w_last) begin
            w_sel_byte = w_chk;
        end else begin
            w_sel_byte = w_pay_sel;
        end
    end

    // SOF and the CHK byte itself stay out of the accumulator.
    assign w_chk_en = (r_state == LOAD) && (r_idx != '0) && !w_last;

    frame_chk u_chk (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_capture),
        .i_en    (w_chk_en),
        .i_data  (w_sel_byte),
        .o_chk   (w_chk)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_set = 1'b0;
        w_done_set  = 1'b0;
        w_idx_inc   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_state_nxt = START;
            end
            START: begin
                if (!tx_busy) begin
                    w_start_set = 1'b1;
                    w_state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A uart_tx that never raises busy still lets the frame progress.
                if (tx_busy || w_to_expired) begin
                    w_state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_state_nxt = LOAD;
                    end
                end
            end
            DONE: begin
                w_done_set  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_to_cnt <= '0;
            r_seq    <= '0;
            r_byte   <= '0;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_start <= w_start_set;
            r_done  <= w_done_set;
            r_drop  <= valid_in & ~r_ready;

            if (w_capture) begin
                r_shadow <= array_in;
                r_ready  <= 1'b0;
            end else if (r_state == DONE) begin
                r_ready <= 1'b1;
                r_seq   <= r_seq + 8'd1;
            end

            if (w_capture) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (r_state == LOAD) begin
                r_byte <= w_sel_byte;
            end

            if (r_state != WAIT_HI) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign ready_out  = r_ready;
    assign byte_out   = r_byte;
    assign start_out  = r_start;
    assign frame_done = r_done;
    assign drop       = r_drop;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a busy-pulse uart_tx model.
// Honors UART_TX_FRAMER_CRC8_EN for the expected CHK byte.
module tb_uart_tx_framer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int NB      = WIDTH * DEPTH / 8;
    localparam int FL      = NB + 4;
    localparam int BUSY_TO = 4;
    localparam int RXN     = 16384;

    typedef logic [DEPTH-1:0][WIDTH-1:0] arr_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       valid_in = 1'b0;
    logic       tx_busy  = 1'b0;
    arr_t       array_in = '0;
    logic       ready_out, start_out, frame_done, drop;
    logic [7:0] byte_out;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] rx     [RXN];
    int         rx_cyc [RXN];
    int         rx_n     = 0;
    int         done_cnt = 0;
    int         drop_cnt = 0;
    int         cyc      = 0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    bit         model_en = 1'b1;
    logic [7:0] exp_b [FL];

    always #5 clk = ~clk;

    uart_tx_framer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .SOF     (8'hA5),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .array_in   (array_in),
        .ready_out  (ready_out),
        .tx_busy    (tx_busy),
        .byte_out   (byte_out),
        .start_out  (start_out),
        .frame_done (frame_done),
        .drop       (drop)
    );

    // uart_tx model and byte/pulse monitor: busy rises one cycle after start_out.
    always @(negedge clk) begin
        cyc++;
        if (start_out) begin
            if (rx_n < RXN) begin
                rx[rx_n]     = byte_out;
                rx_cyc[rx_n] = cyc;
            end
            rx_n++;
        end
        if (frame_done) done_cnt++;
        if (drop) drop_cnt++;
        if (busy_cnt > 0) busy_cnt--;
        if (start_out && model_en) busy_cnt = busy_len;
        tx_busy = (busy_cnt != 0);
    end

    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic build_exp(input logic [7:0] seq, input arr_t a);
        logic [7:0] c;
        c = '0;
        exp_b[0] = 8'hA5;
        exp_b[1] = seq;
        exp_b[2] = 8'(NB);
        for (int e = 0; e < DEPTH; e++)
            for (int b = 0; b < 4; b++)
                exp_b[3 + e*4 + b] = a[e][WIDTH-1-8*b -: 8];
        for (int i = 1; i < FL - 1; i++) begin
`ifdef UART_TX_FRAMER_CRC8_EN
            c = crc_ref(c, exp_b[i]);
`else
            c = c + exp_b[i];
`endif
        end
`ifdef UART_TX_FRAMER_CRC8_EN
        exp_b[FL-1] = c;
`else
        exp_b[FL-1] = ~c + 8'd1;
`endif
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input arr_t a);
        valid_in = 1'b1;
        array_in = a;
        step();
        valid_in = 1'b0;
        array_in = ~a;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (done_cnt > d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        nvec++; if (ready_out !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        nvec++; if (start_out !== 1'b0) begin nerr++; $display("FAIL reset_start: got %b want 0", start_out); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", frame_done); end
        nvec++; if (drop !== 1'b0) begin nerr++; $display("FAIL reset_drop: got %b want 0", drop); end
        nvec++; if (byte_out !== 8'h00) begin nerr++; $display("FAIL reset_byte: got %h want 00", byte_out); end
        rst = 1'b1;
        repeat (2) step();
        nvec++; if (ready_out !== 1'b1) begin nerr++; $display("FAIL post_reset_ready: got %b want 1", ready_out); end
    endtask

    task automatic test_basic();
        arr_t a;
        bit   ok;
        int   base, d0;
        for (int e = 0; e < DEPTH; e++) a[e] = WIDTH'(e + 1);
        base = rx_n; d0 = done_cnt;
        send(a);
        nvec++; if (ready_out !== 1'b0) begin nerr++; $display("FAIL capture_ready_low: got %b want 0", ready_out); end
        wait_done(d0, 2000, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL basic_timeout: got no frame_done want frame_done"); end
        nvec++; if (ready_out !== 1'b1) begin nerr++; $display("FAIL basic_ready_back: got %b want 1", ready_out); end
        build_exp(8'h00, a);
        nvec++; if (rx_n - base != FL) begin nerr++; $display("FAIL basic_len: got %0d want %0d", rx_n - base, FL); end
        for (int i = 0; i < FL; i++) begin
            nvec++;
            if (rx[base+i] !== exp_b[i]) begin
                nerr++; $display("FAIL basic_byte[%0d]: got %h want %h", i, rx[base+i], exp_b[i]);
            end
        end
`ifndef UART_TX_FRAMER_CRC8_EN
        nvec++; if (rx[base+FL-1] !== 8'hBC) begin nerr++; $display("FAIL basic_chk: got %h want bc", rx[base+FL-1]); end
`endif
        nvec++;
        if (rx_cyc[base+1] - rx_cyc[base] != 13) begin
            nerr++; $display("FAIL basic_byte_period: got %0d want 13", rx_cyc[base+1] - rx_cyc[base]);
        end
        repeat (20) step();
        nvec++; if (done_cnt - d0 != 1) begin nerr++; $display("FAIL basic_done_once: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_drop();
        arr_t a1, a2;
        bit   ok;
        int   base, d0, dr0;
        for (int e = 0; e < DEPTH; e++) a1[e] = 32'hDEAD_0000 | WIDTH'(e * 17);
        a2 = ~a1;
        base = rx_n; d0 = done_cnt; dr0 = drop_cnt;
        valid_in = 1'b1; array_in = a1;
        step();
        valid_in = 1'b0; array_in = a2;
        repeat (4) step();
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        nvec++; if (drop !== 1'b1) begin nerr++; $display("FAIL drop_pulse: got %b want 1", drop); end
        step();
        nvec++; if (drop !== 1'b0) begin nerr++; $display("FAIL drop_width: got %b want 0", drop); end
        wait_done(d0, 2000, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL drop_timeout: got no frame_done want frame_done"); end
        build_exp(8'h01, a1);
        for (int i = 0; i < FL; i++) begin
            nvec++;
            if (rx[base+i] !== exp_b[i]) begin
                nerr++; $display("FAIL drop_byte[%0d]: got %h want %h", i, rx[base+i], exp_b[i]);
            end
        end
        repeat (300) step();
        nvec++; if (rx_n - base != FL) begin nerr++; $display("FAIL drop_no_second: got %0d bytes want %0d", rx_n - base, FL); end
        nvec++; if (drop_cnt - dr0 != 1) begin nerr++; $display("FAIL drop_count: got %0d want 1", drop_cnt - dr0); end
        nvec++; if (done_cnt - d0 != 1) begin nerr++; $display("FAIL drop_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_busy_timeout();
        arr_t a;
        bit   ok;
        int   base, d0;
        for (int e = 0; e < DEPTH; e++) a[e] = {8'(e), 8'hF0, 8'h0F, 8'(8*e + 3)};
        model_en = 1'b0;
        base = rx_n; d0 = done_cnt;
        send(a);
        wait_done(d0, 1000, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL to_timeout: got no frame_done want frame_done"); end
        build_exp(8'h02, a);
        for (int i = 0; i < FL; i++) begin
            nvec++;
            if (rx[base+i] !== exp_b[i]) begin
                nerr++; $display("FAIL to_byte[%0d]: got %h want %h", i, rx[base+i], exp_b[i]);
            end
        end
        nvec++;
        if (rx_cyc[base+1] - rx_cyc[base] != BUSY_TO + 3) begin
            nerr++; $display("FAIL to_byte_period: got %0d want %0d", rx_cyc[base+1] - rx_cyc[base], BUSY_TO + 3);
        end
        model_en = 1'b1;
    endtask

    task automatic test_abort_reset();
        arr_t a1, a2;
        bit   ok;
        int   base, d0;
        for (int e = 0; e < DEPTH; e++) a1[e] = 32'h1357_9BDF ^ WIDTH'(e);
        for (int e = 0; e < DEPTH; e++) a2[e] = 32'h8000_0001 + WIDTH'(e << 8);
        base = rx_n;
        send(a1);
        repeat (60) step();
        nvec++; if (rx_n <= base) begin nerr++; $display("FAIL abort_midframe: got %0d bytes want >0", rx_n - base); end
        rst = 1'b0;
        #1;
        nvec++; if (ready_out !== 1'b1) begin nerr++; $display("FAIL abort_ready: got %b want 1", ready_out); end
        nvec++; if (start_out !== 1'b0) begin nerr++; $display("FAIL abort_start: got %b want 0", start_out); end
        nvec++; if (byte_out !== 8'h00) begin nerr++; $display("FAIL abort_byte: got %h want 00", byte_out); end
        nvec++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL abort_done: got %b want 0", frame_done); end
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 30 && tx_busy; i++) step();
        step();
        base = rx_n; d0 = done_cnt;
        send(a2);
        wait_done(d0, 2000, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL abort_timeout: got no frame_done want frame_done"); end
        build_exp(8'h00, a2);
        nvec++; if (rx_n - base != FL) begin nerr++; $display("FAIL abort_len: got %0d want %0d", rx_n - base, FL); end
        for (int i = 0; i < FL; i++) begin
            nvec++;
            if (rx[base+i] !== exp_b[i]) begin
                nerr++; $display("FAIL abort_byte[%0d]: got %h want %h", i, rx[base+i], exp_b[i]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        arr_t       a;
        bit         ok;
        int         base, d0;
        logic [7:0] s;
        for (int e = 0; e < DEPTH; e++) a[e] = WIDTH'(e + 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 30 && tx_busy; i++) step();
        busy_len = 1;
        step();
        for (int f = 0; f < 257; f++) begin
            base = rx_n; d0 = done_cnt;
            send(a);
            wait_done(d0, 400, ok);
            nvec++; if (!ok) begin nerr++; $display("FAIL wrap_timeout[%0d]: got no frame_done want frame_done", f); end
            build_exp(8'(f), a);
            nvec++; if (rx_n - base != FL) begin nerr++; $display("FAIL wrap_len[%0d]: got %0d want %0d", f, rx_n - base, FL); end
            nvec++; if (rx[base+1] !== exp_b[1]) begin nerr++; $display("FAIL wrap_seq[%0d]: got %h want %h", f, rx[base+1], exp_b[1]); end
            nvec++; if (rx[base+FL-1] !== exp_b[FL-1]) begin nerr++; $display("FAIL wrap_chk[%0d]: got %h want %h", f, rx[base+FL-1], exp_b[FL-1]); end
`ifndef UART_TX_FRAMER_CRC8_EN
            s = '0;
            for (int i = 1; i < FL; i++) s = s + rx[base+i];
            nvec++; if (s !== 8'h00) begin nerr++; $display("FAIL wrap_rx_sum[%0d]: got %h want 00", f, s); end
`endif
            if (f == 0) begin
                nvec++;
                if (rx_cyc[base+1] - rx_cyc[base] != 4) begin
                    nerr++; $display("FAIL wrap_byte_period: got %0d want 4", rx_cyc[base+1] - rx_cyc[base]);
                end
            end
        end
        busy_len = 10;
    endtask

    task automatic test_zero_array();
        arr_t a;
        bit   ok;
        int   base, d0;
        a = '0;
        base = rx_n; d0 = done_cnt;
        send(a);
        wait_done(d0, 2000, ok);
        nvec++; if (!ok) begin nerr++; $display("FAIL zero_timeout: got no frame_done want frame_done"); end
        build_exp(8'h01, a);
        for (int i = 0; i < FL; i++) begin
            nvec++;
            if (rx[base+i] !== exp_b[i]) begin
                nerr++; $display("FAIL zero_byte[%0d]: got %h want %h", i, rx[base+i], exp_b[i]);
            end
        end
`ifndef UART_TX_FRAMER_CRC8_EN
        nvec++; if (rx[base+FL-1] !== 8'hDF) begin nerr++; $display("FAIL zero_chk: got %h want df", rx[base+FL-1]); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_busy_timeout();
        test_abort_reset();
        test_seq_wrap();
        test_zero_array();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
